// File: rtl/ctrl_pkg.sv
// Shared control encodings for the multicycle MIPS-subset CPU: states, opcodes, ALU ops, mux selects.
// Latency: n/a (types, constants and a pure state->control-word function).
// Backpressure: none.
package ctrl_pkg;

    typedef enum logic [4:0] {
        ST_RESET      = 5'd0,
        ST_FETCH      = 5'd1,
        ST_FETCH_WAIT = 5'd2,
        ST_DECODE     = 5'd3,
        ST_EXEC_R     = 5'd4,
        ST_WB_R       = 5'd5,
        ST_EXEC_I     = 5'd6,
        ST_WB_I       = 5'd7,
        ST_MEM_ADDR   = 5'd8,
        ST_LW_READ    = 5'd9,
        ST_LW_WAIT    = 5'd10,
        ST_LW_WB      = 5'd11,
        ST_SW         = 5'd12,
        ST_BRANCH     = 5'd13,
        ST_JUMP       = 5'd14,
        ST_JAL        = 5'd15,
        ST_JR         = 5'd16,
        ST_EXC_SAVE   = 5'd17,
        ST_EXC_READ   = 5'd18,
        ST_EXC_WAIT   = 5'd19,
        ST_EXC_JUMP   = 5'd20
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    localparam logic [1:0] IORD_PC     = 2'd0;
    localparam logic [1:0] IORD_ERR    = 2'd1;
    localparam logic [1:0] IORD_ALUOUT = 2'd2;

    localparam logic [2:0] REGDST_RT = 3'd0;
    localparam logic [2:0] REGDST_RD = 3'd1;
    localparam logic [2:0] REGDST_RA = 3'd2;

    localparam logic [3:0] M2R_ALUOUT = 4'd0;
    localparam logic [3:0] M2R_MDR    = 4'd1;
    localparam logic [3:0] M2R_PC     = 4'd2;

    localparam logic       SRCA_PC = 1'b0;
    localparam logic       SRCA_A  = 1'b1;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [2:0] PCSRC_ALU    = 3'd0;
    localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
    localparam logic [2:0] PCSRC_JUMP   = 3'd2;
    localparam logic [2:0] PCSRC_A      = 3'd3;
    localparam logic [2:0] PCSRC_MDR    = 3'd4;

    typedef struct packed {
        logic       pcw;
        logic [1:0] iord;
        logic [1:0] error;
        logic       memwrite;
        logic       irwrite;
        logic       mdrwrite;
        logic [2:0] regdst;
        logic [3:0] memtoreg;
        logic       regwrite;
        logic       rega;
        logic       regb;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] ulactrl;
        logic       regaluout;
        logic       regepc;
        logic [2:0] pcsource;
    } ctrl_t;

    function automatic ctrl_t ctrl_word(state_t st, logic [2:0] rop, logic [1:0] cause);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.iord = IORD_PC;   c.srca = SRCA_PC; c.srcb = SRCB_FOUR;
                c.ulactrl = ALU_ADD; c.pcsource = PCSRC_ALU; c.pcw = 1'b1;
            end
            ST_FETCH_WAIT: c.irwrite = 1'b1;
            ST_DECODE: begin
                c.rega = 1'b1; c.regb = 1'b1;
                c.srca = SRCA_PC; c.srcb = SRCB_IMM_SH; c.ulactrl = ALU_ADD; c.regaluout = 1'b1;
            end
            ST_EXEC_R: begin
                c.srca = SRCA_A; c.srcb = SRCB_B; c.ulactrl = rop; c.regaluout = 1'b1;
            end
            ST_WB_R: begin
                c.regdst = REGDST_RD; c.memtoreg = M2R_ALUOUT; c.regwrite = 1'b1;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                c.srca = SRCA_A; c.srcb = SRCB_IMM; c.ulactrl = ALU_ADD; c.regaluout = 1'b1;
            end
            ST_WB_I: begin
                c.regdst = REGDST_RT; c.memtoreg = M2R_ALUOUT; c.regwrite = 1'b1;
            end
            ST_LW_READ: c.iord = IORD_ALUOUT;
            ST_LW_WAIT: c.mdrwrite = 1'b1;
            ST_LW_WB: begin
                c.regdst = REGDST_RT; c.memtoreg = M2R_MDR; c.regwrite = 1'b1;
            end
            ST_SW: begin
                c.iord = IORD_ALUOUT; c.memwrite = 1'b1;
            end
            // pcw for a branch is resolved combinationally from ula_zero in the top
            ST_BRANCH: begin
                c.srca = SRCA_A; c.srcb = SRCB_B; c.ulactrl = ALU_SUB; c.pcsource = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                c.pcsource = PCSRC_JUMP; c.pcw = 1'b1;
            end
            ST_JAL: begin
                c.regdst = REGDST_RA; c.memtoreg = M2R_PC; c.regwrite = 1'b1;
                c.pcsource = PCSRC_JUMP; c.pcw = 1'b1;
            end
            ST_JR: begin
                c.pcsource = PCSRC_A; c.pcw = 1'b1;
            end
            ST_EXC_SAVE: begin
                c.srca = SRCA_PC; c.srcb = SRCB_FOUR; c.ulactrl = ALU_SUB; c.regepc = 1'b1;
            end
            ST_EXC_READ: begin
                c.iord = IORD_ERR; c.error = cause;
            end
            ST_EXC_WAIT: c.mdrwrite = 1'b1;
            ST_EXC_JUMP: begin
                c.pcsource = PCSRC_MDR; c.pcw = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode/funct decoder: state to enter after DECODE, R-type ALU op, invalid and overflow-check flags.
// Latency: purely combinational.
// Backpressure: none.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output state_t     o_dispatch,
    output logic [2:0] o_alu_op,
    output logic       o_invalid,
    output logic       o_ovf_chk
);

    always_comb begin
        o_dispatch = ST_FETCH;
        o_alu_op   = ALU_ADD;
        o_invalid  = 1'b0;
        o_ovf_chk  = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD: begin o_dispatch = ST_EXEC_R; o_alu_op = ALU_ADD; o_ovf_chk = 1'b1; end
                    FN_SUB: begin o_dispatch = ST_EXEC_R; o_alu_op = ALU_SUB; o_ovf_chk = 1'b1; end
                    FN_AND: begin o_dispatch = ST_EXEC_R; o_alu_op = ALU_AND; end
                    FN_JR:  o_dispatch = ST_JR;
                    default: o_invalid = 1'b1;
                endcase
            end
            OP_ADDI: o_dispatch = ST_EXEC_I;
            OP_LW,
            OP_SW:   o_dispatch = ST_MEM_ADDR;
            OP_BEQ,
            OP_BNE:  o_dispatch = ST_BRANCH;
            OP_J:    o_dispatch = ST_JUMP;
            OP_JAL:  o_dispatch = ST_JAL;
            default: o_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM; exception states and cause register exist only with CTRL_EXCEPTION_EN.
// Latency: Moore outputs registered alongside the state; branch pcw resolves combinationally.
// Backpressure: none, one instruction in flight, fixed cycle count per instruction class.
module control_unit
    import ctrl_pkg::*;
#(
    parameter logic [1:0] ERR_OPCODE = 2'd0,
    parameter logic [1:0] ERR_OVF    = 2'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       ula_overflow,
    input  logic       ula_zero,
    output logic       crtl_pcw,
    output logic [1:0] crtl_iord,
    output logic [1:0] crtl_error,
    output logic       crtl_memwrite,
    output logic       crtl_irwrite,
    output logic       crtl_memDataRegWrite,
    output logic [2:0] crtl_regdst,
    output logic [3:0] crtl_memtoreg,
    output logic       crtl_regwrite,
    output logic       crtl_rega,
    output logic       crtl_regb,
    output logic       crtl_ulasrca,
    output logic [1:0] crtl_ulasrcb,
    output logic [2:0] crtl_ulactrl,
    output logic       crtl_regaluout,
    output logic       crtl_regepc,
    output logic [2:0] crtl_pcsource,
    output logic [4:0] dbg_state
);

    state_t     r_state;
    state_t     w_next;
    ctrl_t      r_ctrl;
    state_t     w_dispatch;
    logic [2:0] w_alu_op;
    logic       w_invalid;
    logic       w_ovf_chk;
    logic [1:0] w_cause;
    logic       w_br_take;

    ctrl_decode u_decode (
        .i_opcode   (opcode),
        .i_funct    (funct),
        .o_dispatch (w_dispatch),
        .o_alu_op   (w_alu_op),
        .o_invalid  (w_invalid),
        .o_ovf_chk  (w_ovf_chk)
    );

`ifdef CTRL_EXCEPTION_EN
    logic [1:0] r_cause;
    assign w_cause = r_cause;
`else
    logic w_unused;
    assign w_cause  = 2'b00;
    assign w_unused = ula_overflow ^ w_ovf_chk ^ (^r_ctrl.error) ^ r_ctrl.regepc;
`endif

    always_comb begin
        w_next = ST_FETCH;
        case (r_state)
            ST_FETCH:      w_next = ST_FETCH_WAIT;
            ST_FETCH_WAIT: w_next = ST_DECODE;
            ST_DECODE: begin
                if (!w_invalid)
                    w_next = w_dispatch;
`ifdef CTRL_EXCEPTION_EN
                else
                    w_next = ST_EXC_SAVE;
`endif
            end
`ifdef CTRL_EXCEPTION_EN
            ST_EXEC_R:     w_next = (w_ovf_chk && ula_overflow) ? ST_EXC_SAVE : ST_WB_R;
            ST_EXEC_I:     w_next = ula_overflow ? ST_EXC_SAVE : ST_WB_I;
            ST_EXC_SAVE:   w_next = ST_EXC_READ;
            ST_EXC_READ:   w_next = ST_EXC_WAIT;
            ST_EXC_WAIT:   w_next = ST_EXC_JUMP;
`else
            ST_EXEC_R:     w_next = ST_WB_R;
            ST_EXEC_I:     w_next = ST_WB_I;
`endif
            ST_MEM_ADDR:   w_next = (opcode == OP_LW) ? ST_LW_READ : ST_SW;
            ST_LW_READ:    w_next = ST_LW_WAIT;
            ST_LW_WAIT:    w_next = ST_LW_WB;
            default:       w_next = ST_FETCH;
        endcase
    end

    // Outputs for the state being entered are registered on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RESET;
            r_ctrl  <= '0;
`ifdef CTRL_EXCEPTION_EN
            r_cause <= 2'b00;
`endif
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_word(w_next, w_alu_op, w_cause);
`ifdef CTRL_EXCEPTION_EN
            if (w_next == ST_EXC_SAVE)
                r_cause <= (r_state == ST_DECODE) ? ERR_OPCODE : ERR_OVF;
`endif
        end
    end

    assign w_br_take = (r_state == ST_BRANCH) && ((opcode == OP_BNE) ? !ula_zero : ula_zero);

    assign crtl_pcw             = r_ctrl.pcw | w_br_take;
    assign crtl_iord            = r_ctrl.iord;
    assign crtl_memwrite        = r_ctrl.memwrite;
    assign crtl_irwrite         = r_ctrl.irwrite;
    assign crtl_memDataRegWrite = r_ctrl.mdrwrite;
    assign crtl_regdst          = r_ctrl.regdst;
    assign crtl_memtoreg        = r_ctrl.memtoreg;
    assign crtl_regwrite        = r_ctrl.regwrite;
    assign crtl_rega            = r_ctrl.rega;
    assign crtl_regb            = r_ctrl.regb;
    assign crtl_ulasrca         = r_ctrl.srca;
    assign crtl_ulasrcb         = r_ctrl.srcb;
    assign crtl_ulactrl         = r_ctrl.ulactrl;
    assign crtl_regaluout       = r_ctrl.regaluout;
    assign crtl_pcsource        = r_ctrl.pcsource;
    assign dbg_state            = r_state;
`ifdef CTRL_EXCEPTION_EN
    assign crtl_error           = r_ctrl.error;
    assign crtl_regepc          = r_ctrl.regepc;
`else
    assign crtl_error           = 2'b00;
    assign crtl_regepc          = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboarded bench for control_unit: instruction-level reference model queues one expected control word per cycle.
module tb_control_unit;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       ula_overflow, ula_zero;
    logic       crtl_pcw, crtl_memwrite, crtl_irwrite, crtl_memDataRegWrite, crtl_regwrite;
    logic       crtl_rega, crtl_regb, crtl_ulasrca, crtl_regaluout, crtl_regepc;
    logic [1:0] crtl_iord, crtl_error, crtl_ulasrcb;
    logic [2:0] crtl_regdst, crtl_ulactrl, crtl_pcsource;
    logic [3:0] crtl_memtoreg;
    logic [4:0] dbg_state;

    control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .ula_overflow(ula_overflow), .ula_zero(ula_zero),
        .crtl_pcw(crtl_pcw), .crtl_iord(crtl_iord), .crtl_error(crtl_error),
        .crtl_memwrite(crtl_memwrite), .crtl_irwrite(crtl_irwrite),
        .crtl_memDataRegWrite(crtl_memDataRegWrite), .crtl_regdst(crtl_regdst),
        .crtl_memtoreg(crtl_memtoreg), .crtl_regwrite(crtl_regwrite),
        .crtl_rega(crtl_rega), .crtl_regb(crtl_regb), .crtl_ulasrca(crtl_ulasrca),
        .crtl_ulasrcb(crtl_ulasrcb), .crtl_ulactrl(crtl_ulactrl),
        .crtl_regaluout(crtl_regaluout), .crtl_regepc(crtl_regepc),
        .crtl_pcsource(crtl_pcsource), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    localparam bit EXC_EN =
`ifdef CTRL_EXCEPTION_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct packed {
        logic       pcw;
        logic [1:0] iord;
        logic [1:0] error;
        logic       memwrite;
        logic       irwrite;
        logic       mdrw;
        logic [2:0] regdst;
        logic [3:0] memtoreg;
        logic       regwrite;
        logic       rega;
        logic       regb;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] ulactrl;
        logic       regaluout;
        logic       regepc;
        logic [2:0] pcsource;
    } word_t;

    typedef struct {
        word_t w;
        bit    in_reset;
        int    tag;
        int    cyc;
    } exp_t;

    typedef enum int {K_ADD, K_SUB, K_AND, K_JR, K_ADDI, K_LW, K_SW,
                      K_BEQ, K_BNE, K_J, K_JAL, K_BAD} kind_t;

    exp_t  sb[$];
    exp_t  m_e;
    word_t act;
    int    checks = 0;
    int    errors = 0;
    int    tag = 0;

    assign act = {crtl_pcw, crtl_iord, crtl_error, crtl_memwrite, crtl_irwrite,
                  crtl_memDataRegWrite, crtl_regdst, crtl_memtoreg, crtl_regwrite,
                  crtl_rega, crtl_regb, crtl_ulasrca, crtl_ulasrcb, crtl_ulactrl,
                  crtl_regaluout, crtl_regepc, crtl_pcsource};

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            if (fn == 6'h20) return K_ADD;
            if (fn == 6'h22) return K_SUB;
            if (fn == 6'h24) return K_AND;
            if (fn == 6'h08) return K_JR;
            return K_BAD;
        end
        if (op == 6'h08) return K_ADDI;
        if (op == 6'h23) return K_LW;
        if (op == 6'h2B) return K_SW;
        if (op == 6'h04) return K_BEQ;
        if (op == 6'h05) return K_BNE;
        if (op == 6'h02) return K_J;
        if (op == 6'h03) return K_JAL;
        return K_BAD;
    endfunction

    function automatic word_t alu(input logic a, input logic [1:0] b, input logic [2:0] op);
        word_t w;
        w = '0;
        w.srca = a; w.srcb = b; w.ulactrl = op;
        return w;
    endfunction

    // Builds the whole expected per-cycle trace for one instruction, queues it, then drives it.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input logic ovf, input logic zero, input int cut);
        word_t q[$];
        word_t w;
        kind_t k;
        bit    exc;
        logic [1:0] cause;
        int    n;
        k = classify(op, fn);
        exc = 1'b0;
        cause = 2'd0;
        w = alu(1'b0, 2'd1, 3'd1); w.pcw = 1'b1; q.push_back(w);
        w = '0; w.irwrite = 1'b1; q.push_back(w);
        w = alu(1'b0, 2'd3, 3'd1); w.rega = 1'b1; w.regb = 1'b1; w.regaluout = 1'b1; q.push_back(w);
        case (k)
            K_ADD, K_SUB, K_AND, K_ADDI: begin
                w = alu(1'b1, (k == K_ADDI) ? 2'd2 : 2'd0,
                        (k == K_SUB) ? 3'd2 : (k == K_AND) ? 3'd3 : 3'd1);
                w.regaluout = 1'b1; q.push_back(w);
                if (EXC_EN && ovf && k != K_AND) begin
                    exc = 1'b1; cause = 2'd1;
                end else begin
                    w = '0; w.regdst = (k == K_ADDI) ? 3'd0 : 3'd1; w.regwrite = 1'b1; q.push_back(w);
                end
            end
            K_LW, K_SW: begin
                w = alu(1'b1, 2'd2, 3'd1); w.regaluout = 1'b1; q.push_back(w);
                if (k == K_LW) begin
                    w = '0; w.iord = 2'd2; q.push_back(w);
                    w = '0; w.mdrw = 1'b1; q.push_back(w);
                    w = '0; w.memtoreg = 4'd1; w.regwrite = 1'b1; q.push_back(w);
                end else begin
                    w = '0; w.iord = 2'd2; w.memwrite = 1'b1; q.push_back(w);
                end
            end
            K_BEQ, K_BNE: begin
                w = alu(1'b1, 2'd0, 3'd2); w.pcsource = 3'd1;
                w.pcw = (k == K_BEQ) ? zero : ~zero; q.push_back(w);
            end
            K_J:   begin w = '0; w.pcsource = 3'd2; w.pcw = 1'b1; q.push_back(w); end
            K_JAL: begin
                w = '0; w.regdst = 3'd2; w.memtoreg = 4'd2; w.regwrite = 1'b1;
                w.pcsource = 3'd2; w.pcw = 1'b1; q.push_back(w);
            end
            K_JR:  begin w = '0; w.pcsource = 3'd3; w.pcw = 1'b1; q.push_back(w); end
            default: if (EXC_EN) begin exc = 1'b1; cause = 2'd0; end
        endcase
        if (exc) begin
            w = alu(1'b0, 2'd1, 3'd2); w.regepc = 1'b1; q.push_back(w);
            w = '0; w.iord = 2'd1; w.error = cause; q.push_back(w);
            w = '0; w.mdrw = 1'b1; q.push_back(w);
            w = '0; w.pcsource = 3'd4; w.pcw = 1'b1; q.push_back(w);
        end
        n = (cut > 0 && cut < q.size()) ? cut : q.size();
        tag++;
        for (int i = 0; i < n; i++) sb.push_back('{w: q[i], in_reset: 1'b0, tag: tag, cyc: i + 1});
        opcode = op; funct = fn; ula_overflow = ovf; ula_zero = zero;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge: pulls rst low mid-cycle for three checked cycles.
    task automatic mid_reset();
        #1 rst = 1'b0;
        tag++;
        for (int i = 0; i < 3; i++) sb.push_back('{w: '0, in_reset: 1'b1, tag: tag, cyc: i + 1});
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            m_e = sb.pop_front();
            checks++;
            if (act !== m_e.w || (m_e.in_reset && dbg_state !== ST_RESET)) begin
                errors++;
                $display("FAIL ctrl_word instr %0d cycle %0d: got %h state %0d, want %h%s",
                         m_e.tag, m_e.cyc, act, dbg_state, m_e.w, m_e.in_reset ? " state RESET" : "");
            end
        end
    end

    logic [5:0] v_op [11] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] v_fn [11] = '{6'h20, 6'h22, 6'h24, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    initial begin
        rst = 1'b1; opcode = '0; funct = '0; ula_overflow = 1'b0; ula_zero = 1'b0;
        #1 rst = 1'b0;
        tag++;
        for (int i = 0; i < 3; i++) sb.push_back('{w: '0, in_reset: 1'b1, tag: tag, cyc: i + 1});
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        mid_reset();
        issue(6'h00, 6'h20, 1'b0, 1'b0, 0);
        issue(6'h23, 6'h15, 1'b0, 1'b1, 0);
        issue(6'h2B, 6'h00, 1'b0, 1'b0, 0);
        issue(6'h04, 6'h00, 1'b0, 1'b1, 0);
        issue(6'h05, 6'h00, 1'b0, 1'b1, 0);
        issue(6'h04, 6'h00, 1'b0, 1'b0, 0);
        issue(6'h05, 6'h00, 1'b0, 1'b0, 0);
        issue(6'h00, 6'h20, 1'b1, 1'b0, 0);
        issue(6'h00, 6'h22, 1'b1, 1'b0, 0);
        issue(6'h00, 6'h24, 1'b1, 1'b0, 0);
        issue(6'h08, 6'h3A, 1'b1, 1'b0, 0);
        issue(6'h3F, 6'h00, 1'b0, 1'b0, 0);
        issue(6'h00, 6'h21, 1'b0, 1'b0, 0);
        issue(6'h03, 6'h00, 1'b0, 1'b0, 0);
        issue(6'h00, 6'h08, 1'b0, 1'b0, 0);
        issue(6'h02, 6'h00, 1'b0, 1'b0, 0);
        issue(6'h23, 6'h00, 1'b0, 1'b0, 5);
        mid_reset();
        issue(6'h2B, 6'h00, 1'b0, 1'b0, 0);
        for (int n = 0; n < 200; n++) begin
            int sel;
            logic [5:0] op, fn;
            sel = $urandom_range(0, 13);
            if (sel < 11) begin
                op = v_op[sel];
                fn = (op == 6'h00) ? v_fn[sel] : 6'($urandom);
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            if (n % 37 == 36) begin
                issue(op, fn, 1'($urandom), 1'($urandom), $urandom_range(1, 6));
                mid_reset();
            end else begin
                issue(op, fn, ($urandom_range(0, 3) == 0), 1'($urandom), 0);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
